// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: left-to-right binary Montgomery exponentiation sequencer for an external multiplier.
// Define MODEXP_CYCLE_CNT_EN to add the saturating 32-bit busy-cycle counter output cycle_cnt.
module mod_exp_ctrl #(
    parameter int WIDTH   = 1024,
    parameter int E_WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [E_WIDTH-1:0] exp,
    input  logic [5:0]         exp_len,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   n,
    input  logic [WIDTH-1:0]   r2n,
    input  logic [WIDTH-1:0]   rn,
    output logic               mm_start,
    output logic [WIDTH-1:0]   mm_a,
    output logic [WIDTH-1:0]   mm_b,
    output logic [WIDTH-1:0]   mm_m,
    input  logic [WIDTH-1:0]   mm_result,
    input  logic               mm_done,
    output logic               busy,
    output logic               done,
`ifdef MODEXP_CYCLE_CNT_EN
    output logic [31:0]        cycle_cnt,
`endif
    output logic [WIDTH-1:0]   result
);
    localparam int IW = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, XT, SQ, MUL, FIN, DONE} state_t;

    state_t             state, state_d;
    logic               pend, pend_d;
    logic [E_WIDTH-1:0] exp_q;
    logic [WIDTH-1:0]   x_q, n_q, r2n_q, rn_q, a_q, xt_q, res_q;
    logic [IW-1:0]      i_q;
    logic               zero_q;
    logic [31:0]        eff_len;
    logic               accept, mm_state, fire, last;

    assign eff_len  = (32'(exp_len) > 32'(E_WIDTH)) ? 32'(E_WIDTH) : 32'(exp_len);
    assign accept   = (state == IDLE) && start;
    assign mm_state = (state == XT) || (state == SQ) || (state == MUL) || (state == FIN);
    // pend marks the issue cycle of a multiply; completions are only honoured after it
    assign fire     = mm_state && !pend && mm_done;
    assign last     = (i_q == '0);

    assign mm_start = pend;
    assign mm_m     = n_q;
    assign mm_a     = (state == XT) ? x_q : a_q;
    assign mm_b     = (state == XT) ? r2n_q : (state == SQ) ? a_q : (state == MUL) ? xt_q : WIDTH'(1);
    assign busy     = mm_state;
    assign done     = (state == DONE);
    assign result   = res_q;

    always_comb begin
        state_d = state;
        pend_d  = accept || (fire && state != FIN);
        if (accept)
            state_d = XT;
        else if (state == DONE)
            state_d = IDLE;
        else if (fire)
            state_d = (state == FIN) ? DONE :
                      (state == XT)  ? (zero_q ? FIN : SQ) :
                      (state == SQ && exp_q[i_q]) ? MUL :
                      last ? FIN : SQ;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            pend  <= 1'b0;
        end else begin
            state <= state_d;
            pend  <= pend_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exp_q  <= '0;
            x_q    <= '0;
            n_q    <= '0;
            r2n_q  <= '0;
            rn_q   <= '0;
            a_q    <= '0;
            xt_q   <= '0;
            res_q  <= '0;
            i_q    <= '0;
            zero_q <= 1'b0;
        end else if (accept) begin
            exp_q  <= exp;
            x_q    <= x;
            n_q    <= n;
            r2n_q  <= r2n;
            rn_q   <= rn;
            i_q    <= IW'(eff_len - 32'd1);
            zero_q <= (eff_len == '0);
        end else if (fire) begin
            if (state == XT) begin
                xt_q <= mm_result;
                a_q  <= rn_q;
            end else if (state == FIN) begin
                res_q <= mm_result;
            end else begin
                a_q <= mm_result;
                // a set bit keeps the index for the following multiply
                if (state == MUL || !exp_q[i_q])
                    i_q <= i_q - IW'(1);
            end
        end
    end

`ifdef MODEXP_CYCLE_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            cycle_cnt <= '0;
        else if (accept)
            cycle_cnt <= '0;
        else if (busy && cycle_cnt != '1)
            cycle_cnt <= cycle_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// tb_mod_exp_ctrl: directed bench with a Montgomery multiplier model and op/result scoreboard.
module tb_mod_exp_ctrl;
    localparam int W = 1024;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic [31:0]  exp = '0;
    logic [5:0]   exp_len = '0;
    logic [W-1:0] x = '0, n = '0, r2n = '0, rn = '0;
    logic [W-1:0] mm_a, mm_b, mm_m, mm_result, result;
    logic         mm_start, mm_done, busy, done;
`ifdef MODEXP_CYCLE_CNT_EN
    logic [31:0]  cycle_cnt;
`endif

    int vec = 0, mis = 0;
    int n_mm = 0, n_done = 0, n_busy = 0, lat = 3;
    bit early = 0, inject = 0, prev_mm_done = 0;
    logic [W-1:0] x_cur = '0, n_cur = '0, r2n_cur = '0, rn_cur = '0;
    int exp_ops[$];
    logic [W-1:0] exp_res[$];

    mod_exp_ctrl #(.WIDTH(W), .E_WIDTH(32)) dut (
        .clk(clk), .resetn(resetn), .start(start), .exp(exp), .exp_len(exp_len),
        .x(x), .n(n), .r2n(r2n), .rn(rn),
        .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
        .mm_result(mm_result), .mm_done(mm_done),
        .busy(busy), .done(done),
`ifdef MODEXP_CYCLE_CNT_EN
        .cycle_cnt(cycle_cnt),
`endif
        .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        vec++;
        assert (got === want) else begin
            mis++;
            $error("FAIL %s: got ..%0h want ..%0h", tag, got[127:0], want[127:0]);
        end
    endtask

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [W-1:0] rx();
        logic [W-1:0] v;
        v = rand_w();
        v[W-1] = 1'b0;
        return v;
    endfunction

    function automatic logic [W-1:0] pow2mod(input int k, input logic [W-1:0] m);
        logic [W+1:0] r, mm;
        r = 1;
        mm = {2'b0, m};
        for (int i = 0; i < k; i++) begin
            r = r << 1;
            if (r >= mm) r = r - mm;
        end
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m);
        logic [W+1:0] t;
        t = '0;
        for (int i = 0; i < W; i++) begin
            if (a[i]) t = t + {2'b0, b};
            if (t[0]) t = t + {2'b0, m};
            t = t >> 1;
        end
        if (t >= {2'b0, m}) t = t - {2'b0, m};
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] modmul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m);
        logic [W+1:0] r, mm;
        r = '0;
        mm = {2'b0, m};
        for (int i = W - 1; i >= 0; i--) begin
            r = r << 1;
            if (r >= mm) r = r - mm;
            if (a[i]) r = r + {2'b0, b};
            if (r >= mm) r = r - mm;
        end
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [31:0] e, input int len, input logic [W-1:0] m);
        logic [W-1:0] r;
        r = W'(1);
        for (int i = len - 1; i >= 0; i--) begin
            r = modmul(r, r, m);
            if (e[i]) r = modmul(r, b, m);
        end
        return r;
    endfunction

    // Multiplier model: done strobe lat cycles after the mm_start cycle
    initial begin : mm_model
        int cnt;
        logic [W-1:0] r;
        cnt = 0;
        r = '0;
        mm_done = 1'b0;
        mm_result = '0;
        forever begin
            @(posedge clk);
            #1;
            mm_done = 1'b0;
            if (!resetn) cnt = 0;
            else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        mm_done = 1'b1;
                        mm_result = r;
                    end
                end
                if (mm_start) begin
                    r = mont(mm_a, mm_b, mm_m);
                    cnt = lat;
                    if (early) begin
                        mm_done = 1'b1;
                        mm_result = ~r;
                    end
                end
                if (inject) begin
                    mm_done = 1'b1;
                    mm_result = '1;
                end
            end
        end
    end

    initial begin : monitor
        int op;
        forever begin
            @(negedge clk);
            if (busy) n_busy++;
            if (mm_start) begin
                n_mm++;
                op = (mm_a === x_cur && mm_b === r2n_cur) ? 0 : (mm_b === W'(1)) ? 3 : (mm_a === mm_b) ? 1 : 2;
                if (exp_ops.size() > 0) chk("mm_op", W'(op), W'(exp_ops.pop_front()));
                else chk("mm_op_unexpected", W'(op), W'(99));
                chk("mm_m", mm_m, n_cur);
            end
            if (done) begin
                n_done++;
                chk("done_after_mm_done", W'(prev_mm_done), W'(1));
                if (exp_res.size() > 0) chk("result", result, exp_res.pop_front());
                else chk("done_unexpected", W'(done), '0);
            end
            prev_mm_done = mm_done;
        end
    end

    task automatic run(input logic [31:0] e, input logic [5:0] len, input logic [W-1:0] xx, input bit poke);
        int eff, cnt_ops, m0, d0;
        logic [W-1:0] want;
        eff = (len > 6'd32) ? 32 : int'(len);
        x_cur = xx;
        cnt_ops = 2;
        exp_ops.push_back(0);
        for (int i = eff - 1; i >= 0; i--) begin
            exp_ops.push_back(1);
            cnt_ops++;
            if (e[i]) begin
                exp_ops.push_back(2);
                cnt_ops++;
            end
        end
        exp_ops.push_back(3);
        want = modexp(xx, e, eff, n_cur);
        exp_res.push_back(want);
        x = xx; exp = e; exp_len = len; n = n_cur; r2n = r2n_cur; rn = rn_cur;
        m0 = n_mm;
        d0 = n_done;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 5000 && n_done == d0; c++) begin
            @(negedge clk);
            start = poke && (n_mm - m0 == 2);
            if (start) x = ~xx;
        end
        start = 1'b0;
        chk("done_seen", W'(n_done - d0), W'(1));
        chk("mm_start_count", W'(n_mm - m0), W'(cnt_ops));
        @(negedge clk);
        chk("idle_busy", W'(busy), '0);
        chk("done_width", W'(done), '0);
        chk("result_held", result, want);
        chk("ops_drained", W'(exp_ops.size()), '0);
        exp_ops.delete();
        exp_res.delete();
    endtask

    initial begin
        int m0, d0, b0;
        n_cur = rand_w();
        n_cur[W-1] = 1'b1;
        n_cur[0] = 1'b1;
        rn_cur = pow2mod(W, n_cur);
        r2n_cur = pow2mod(2 * W, n_cur);
        repeat (3) @(negedge clk);
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_mm_start", W'(mm_start), '0);
        chk("rst_result", result, '0);
        resetn = 1'b1;
        @(negedge clk);

        run(32'hB, 6'd4, rx(), 1'b0);
        run(32'h0, 6'd0, rx(), 1'b0);
        run(32'hFFFF_FFFF, 6'd40, rx(), 1'b0);
        run(32'h2D, 6'd6, rx(), 1'b1);
        early = 1'b1;
        run(32'h6, 6'd3, rx(), 1'b0);
        early = 1'b0;

        // abort in MUL, then a stray completion must not revive the FSM
        x_cur = rx();
        exp_ops.push_back(0);
        exp_ops.push_back(1);
        exp_ops.push_back(2);
        x = x_cur; exp = 32'hB; exp_len = 6'd4;
        m0 = n_mm;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200 && n_mm - m0 < 3; c++) @(negedge clk);
        chk("abort_in_mul", W'(n_mm - m0), W'(3));
        resetn = 1'b0;
        #1;
        chk("abort_busy", W'(busy), '0);
        chk("abort_mm_start", W'(mm_start), '0);
        chk("abort_done", W'(done), '0);
        chk("abort_result", result, '0);
        exp_ops.delete();
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        d0 = n_done;
        b0 = n_busy;
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        repeat (6) @(negedge clk);
        chk("stray_no_done", W'(n_done - d0), '0);
        chk("stray_no_busy", W'(n_busy - b0), '0);

        run(32'h5, 6'd3, rx(), 1'b0);

`ifdef MODEXP_CYCLE_CNT_EN
        lat = 10;
        b0 = n_busy;
        run(32'h1, 6'd1, rx(), 1'b0);
        chk("cycle_cnt", W'(cycle_cnt), W'(n_busy - b0));
        repeat (3) @(negedge clk);
        chk("cycle_cnt_frozen", W'(cycle_cnt), W'(n_busy - b0));
        lat = 3;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end
endmodule
